// File: rtl/encoder8_if.sv
// Request/acknowledge bus between the encoder8 priority encoder and its
// producer/consumer side.
interface encoder8_if;
  logic [7:0] REQ;
  logic       ACK;
  logic [2:0] X;
  logic       VALID;
  logic [7:0] PEND;
  logic       OVF;

  // Driving side: issues request pulses and acknowledges presented indices.
  modport master (
    output REQ,
    output ACK,
    input  X,
    input  VALID,
    input  PEND,
    input  OVF
  );

  // Encoder side.
  modport slave (
    input  REQ,
    input  ACK,
    output X,
    output VALID,
    output PEND,
    output OVF
  );
endinterface

// File: rtl/encoder8.sv
// Registered 8-to-3 priority encoder with valid/acknowledge handshake.
// Request pulses accumulate in a pending set; the highest-numbered pending
// line is presented on X and held until acknowledged.
module encoder8 (
  input logic      CLK,
  input logic      RST,
  encoder8_if.slave bus
);

  logic [2:0] xReg;
  logic       validReg;
  logic [7:0] pendReg;
  logic       ovfReg;

  logic [7:0] merged;
  logic       loadEn;
  logic       anyPending;
  logic [2:0] selIdx;

  // Merge new pulses into the pending set and pick the highest set line.
  always_comb begin
    merged     = pendReg | bus.REQ;
    loadEn     = !validReg || bus.ACK;
    anyPending = |merged;
    selIdx     = 3'd0;
    // Ascending scan: the last hit is the highest line, which wins.
    for (int i = 0; i < 8; i++) begin
      if (merged[i]) begin
        selIdx = 3'(i);
      end
    end
  end

  // Handshake state, pending set and overflow pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xReg     <= 3'd0;
      validReg <= 1'b0;
      pendReg  <= 8'h00;
      ovfReg   <= 1'b0;
    end else begin
      // Duplicate against the pre-edge set; the set cannot count it.
      ovfReg <= |(bus.REQ & pendReg);
      if (loadEn) begin
        if (anyPending) begin
          xReg     <= selIdx;
          validReg <= 1'b1;
          pendReg  <= merged & ~(8'h01 << selIdx);
        end else begin
          // X keeps its last value when going idle.
          validReg <= 1'b0;
          pendReg  <= 8'h00;
        end
      end else begin
        pendReg <= merged;
      end
    end
  end

  assign bus.X     = xReg;
  assign bus.VALID = validReg;
  assign bus.PEND  = pendReg;
  assign bus.OVF   = ovfReg;

endmodule

// File: tb/tb_encoder8.sv
// Directed, table-driven bench for encoder8.
module tb_encoder8;

  logic clk;
  logic rst;

  encoder8_if bus ();

  encoder8 dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [2:0] expX;
    logic       expValid;
    logic [7:0] expPend;
    logic       expOvf;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic r, input logic [7:0] req,
                        input logic ack, input logic [2:0] x, input logic v,
                        input logic [7:0] p, input logic o);
    vec_t t;
    t.name = name; t.rst = r; t.req = req; t.ack = ack;
    t.expX = x; t.expValid = v; t.expPend = p; t.expOvf = o;
    vecs.push_back(t);
  endtask

  task automatic checkAll(input string name, input logic [2:0] x, input logic v,
                          input logic [7:0] p, input logic o);
    checkVal({name, ".X"}, {5'd0, bus.X}, {5'd0, x});
    checkVal({name, ".VALID"}, {7'd0, bus.VALID}, {7'd0, v});
    checkVal({name, ".PEND"}, bus.PEND, p);
    checkVal({name, ".OVF"}, {7'd0, bus.OVF}, {7'd0, o});
  endtask

  initial begin
    bit seen;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.REQ = 8'hFF;
    bus.ACK = 1'b1;

    //     name        rst req    ack  X  V  PEND   OVF
    addVec("rst0",     1, 8'hFF, 1, 0, 0, 8'h00, 0);
    addVec("rst1",     1, 8'hFF, 1, 0, 0, 8'h00, 0);
    addVec("idle",     0, 8'h00, 0, 0, 0, 8'h00, 0);
    addVec("single",   0, 8'h20, 0, 5, 1, 8'h00, 0);
    addVec("singAck",  0, 8'h00, 1, 5, 0, 8'h00, 0);
    addVec("pri7",     0, 8'h96, 1, 7, 1, 8'h16, 0);
    addVec("pri4",     0, 8'h00, 1, 4, 1, 8'h06, 0);
    addVec("pri2",     0, 8'h00, 1, 2, 1, 8'h02, 0);
    addVec("pri1",     0, 8'h00, 1, 1, 1, 8'h00, 0);
    addVec("priEnd",   0, 8'h00, 1, 1, 0, 8'h00, 0);
    addVec("hold0",    0, 8'h08, 0, 3, 1, 8'h00, 0);
    addVec("hold1",    0, 8'h80, 0, 3, 1, 8'h80, 0);
    addVec("hold2",    0, 8'h00, 0, 3, 1, 8'h80, 0);
    addVec("hold3",    0, 8'h80, 0, 3, 1, 8'h80, 1);
    addVec("hold4",    0, 8'h00, 0, 3, 1, 8'h80, 0);
    addVec("hold5",    0, 8'h00, 0, 3, 1, 8'h80, 0);
    addVec("holdAck",  0, 8'h00, 1, 7, 1, 8'h00, 0);
    addVec("holdEnd",  0, 8'h00, 1, 7, 0, 8'h00, 0);
    addVec("ovfLoad",  0, 8'h03, 0, 1, 1, 8'h01, 0);
    addVec("ovfDup",   0, 8'h01, 0, 1, 1, 8'h01, 1);
    addVec("ovfNew",   0, 8'h02, 0, 1, 1, 8'h03, 0);
    addVec("reLoad1",  0, 8'h00, 1, 1, 1, 8'h01, 0);
    addVec("reLoad0",  0, 8'h00, 1, 0, 1, 8'h00, 0);
    addVec("ovfEnd",   0, 8'h00, 1, 0, 0, 8'h00, 0);
    addVec("midLoad",  0, 8'h4F, 0, 6, 1, 8'h0F, 0);
    addVec("midRst",   1, 8'hFF, 0, 0, 0, 8'h00, 0);
    addVec("postRst",  0, 8'h04, 0, 2, 1, 8'h00, 0);
    addVec("sameLine", 0, 8'h04, 0, 2, 1, 8'h04, 0);
    addVec("sameAck",  0, 8'h00, 1, 2, 1, 8'h00, 0);
    addVec("sameEnd",  0, 8'h00, 1, 2, 0, 8'h00, 0);
    addVec("b2bLoad",  0, 8'h10, 1, 4, 1, 8'h00, 0);
    addVec("b2bNew",   0, 8'h01, 1, 0, 1, 8'h00, 0);
    addVec("b2bEnd",   0, 8'h00, 1, 0, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      bus.REQ = vecs[i].req;
      bus.ACK = vecs[i].ack;
      @(posedge clk);
      #1;
      checkAll(vecs[i].name, vecs[i].expX, vecs[i].expValid, vecs[i].expPend,
               vecs[i].expOvf);
    end

    // Outputs must not follow inputs between edges.
    bus.REQ = 8'hFF;
    bus.ACK = 1'b1;
    #2;
    checkAll("noComb", 3'd0, 1'b0, 8'h00, 1'b0);

    // Bounded wait for a request presented from idle.
    @(posedge clk);
    #1;
    bus.REQ = 8'h00;
    bus.ACK = 1'b0;
    @(posedge clk);
    #1;
    checkAll("drain", 3'd7, 1'b1, 8'h7F, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.REQ = 8'h40;
    seen    = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk);
      #1;
      bus.REQ = 8'h00;
      seen    = bus.VALID;
    end
    checkVal("waitValid", {7'd0, seen}, 8'h01);
    checkVal("waitX", {5'd0, bus.X}, 8'h06);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
